// File: rtl/spi_reg_pkg.sv
// Shared types and default widths for the SPI-to-register-store bridge.
// Imported by the bridge, its interface and the testbench.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA,
    DRAIN
  } state_e;

  localparam logic RW_READ    = 1'b1;
  localparam int   DEF_ADDR_W = 7;
  localparam int   DEF_DATA_W = 8;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Register-store bus driven by the SPI bridge.
// Write/read strobes, address, write data and registered read data.
interface spi_reg_bridge_if
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (
    output wr, rd, addr, data_in,
    input  data_out
  );

  modport slave (
    input  wr, rd, addr, data_in,
    output data_out
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an async pin with rise/fall pulse outputs.
// Edges are taken between the last stage and one extra history flop.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   lvl;

  assign lvl = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = lvl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave turning {rw,addr}+data frames into single-cycle
// register-store strobes; read data is shifted back out on MISO.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic             frame_err,
  spi_reg_bridge_if.master bus
);

  localparam int RX_W  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int SR_W  = RX_W - 1;
  localparam int CNT_W = $clog2(RX_W + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic mosi_s;
  logic [RX_W-1:0] rx_word;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic wr_q, wr_d, rd_q, rd_d, ld_q, ld_d;
  logic oe_q, oe_d, ferr_q, ferr_d;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign rx_word = {rx_q, mosi_s};

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ld_d    = rd_q;
    oe_d    = oe_q;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
          oe_d    = 1'b1;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          rx_d  = rx_word[SR_W-1:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CMD_LAST) begin
            addr_d = rx_word[ADDR_W-1:0];
            cnt_d  = '0;
            if (rx_word[ADDR_W] == RW_READ) begin
              rd_d    = 1'b1;
              state_d = RD_DATA;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
      end
      WR_DATA: begin
        if (sclk_rise) begin
          rx_d  = rx_word[SR_W-1:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == DATA_LAST) begin
            data_d  = rx_word[DATA_W-1:0];
            wr_d    = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      RD_DATA: begin
        // Fall after the last command bit has cnt 0 and must not shift.
        if (ld_q) begin
          tx_d = bus.data_out;
        end else if (sclk_fall && cnt_q != '0) begin
          tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
        if (sclk_rise) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == DATA_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
      end
      default: state_d = IDLE;
    endcase
    if (cs_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      ferr_d  = (state_q == CMD && cnt_q != '0) ||
                state_q == WR_DATA || state_q == RD_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      mosi_sync_q <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      ld_q        <= 1'b0;
      oe_q        <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mosi_sync_q <= mosi_sync_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ld_q        <= ld_d;
      oe_q        <= oe_d;
      ferr_q      <= ferr_d;
    end
  end

  assign miso        = (state_q == RD_DATA) & tx_q[DATA_W-1];
  assign miso_oe     = oe_q;
  assign frame_err   = ferr_q;
  assign bus.wr      = wr_q;
  assign bus.rd      = rd_q;
  assign bus.addr    = addr_q;
  assign bus.data_in = data_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: SPI master tasks, 8x8 store model and
// scoreboard queues for write, read and MISO expectations.
module tb_spi_reg_bridge;
  import spi_reg_pkg::*;

  logic clk = 1'b0;
  logic rst_n, sclk, cs_n, mosi;
  logic miso, miso_oe, frame_err;

  spi_reg_bridge_if bus ();

  spi_reg_bridge dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .frame_err(frame_err),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  logic [7:0] mem     [8] = '{default: 8'h00};
  logic [7:0] ref_mem [8] = '{default: 8'h00};

  always @(posedge clk) begin
    if (bus.wr) mem[bus.addr[2:0]] <= bus.data_in;
    if (bus.rd) bus.data_out <= mem[bus.addr[2:0]];
  end

  int tests = 0;
  int fails = 0;
  int ferr_cnt = 0;

  logic [14:0] exp_wr   [$];
  logic [6:0]  exp_rd   [$];
  logic [7:0]  exp_miso [$];
  logic [14:0] we;
  logic [6:0]  re;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (bus.wr === 1'b1 || bus.rd === 1'b1)
      check("wr_rd_excl", 32'(bus.wr & bus.rd), 32'd0);
    if (bus.wr === 1'b1) begin
      check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        we = exp_wr.pop_front();
        check("wr_addr", 32'(bus.addr), 32'(we[14:8]));
        check("wr_data", 32'(bus.data_in), 32'(we[7:0]));
      end
    end
    if (bus.rd === 1'b1) begin
      check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) begin
        re = exp_rd.pop_front();
        check("rd_addr", 32'(bus.addr), 32'(re));
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n,
                          output logic [7:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #250;
      sclk = 1'b1;
      r[7-i] = miso;
      #250;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    cs_n = 1'b0;
    #250;
  endtask

  task automatic cs_hi();
    #250;
    cs_n = 1'b1;
    #500;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] r;
    ref_mem[a[2:0]] = d;
    exp_wr.push_back({a, d});
    cs_lo();
    spi_bits({1'b0, a}, 8, r);
    check("wr_cmd_miso", 32'(r), 32'd0);
    spi_bits(d, 8, r);
    check("wr_data_miso", 32'(r), 32'd0);
    cs_hi();
  endtask

  task automatic do_read(input logic [6:0] a, input logic [7:0] filler);
    logic [7:0] r;
    logic [7:0] e;
    exp_rd.push_back(a);
    exp_miso.push_back(ref_mem[a[2:0]]);
    cs_lo();
    spi_bits({RW_READ, a}, 8, r);
    check("rd_cmd_miso", 32'(r), 32'd0);
    spi_bits(filler, 8, r);
    e = exp_miso.pop_front();
    check("rd_miso_byte", 32'(r), 32'(e));
    cs_hi();
  endtask

  initial begin
    logic [7:0] r;
    int f0;
    rst_n = 1'b0;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    #53;
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_wr", 32'(bus.wr), 32'd0);
    check("rst_rd", 32'(bus.rd), 32'd0);
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_data_in", 32'(bus.data_in), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    #50;
    rst_n = 1'b1;
    #200;

    // 1: write 0x03,0xA5
    do_write(7'd3, 8'hA5);
    check("t1_store3", 32'(mem[3]), 32'hA5);
    check("t1_addr_hold", 32'(bus.addr), 32'd3);
    check("t1_data_hold", 32'(bus.data_in), 32'hA5);
    check("t1_oe_off", 32'(miso_oe), 32'd0);

    // 2: read back address 3
    do_read(7'd3, 8'h00);
    check("t2_addr_hold", 32'(bus.addr), 32'd3);

    // 3: top address and an unwritten one
    do_write(7'd7, 8'h3C);
    do_read(7'd7, 8'hFF);
    do_read(7'd5, 8'h00);

    // 4: aborted write keeps the previous store contents
    do_write(7'd2, 8'h5A);
    f0 = ferr_cnt;
    cs_lo();
    spi_bits(8'h02, 8, r);
    cs_n = 1'b0;
    spi_bits(8'hF0, 4, r);
    cs_hi();
    check("t4_ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    check("t4_oe_off", 32'(miso_oe), 32'd0);
    check("t4_store2", 32'(mem[2]), 32'h5A);
    do_read(7'd2, 8'h00);

    // 5: extra bytes after the data word are ignored
    f0 = ferr_cnt;
    ref_mem[1] = 8'h11;
    exp_wr.push_back({7'd1, 8'h11});
    cs_lo();
    spi_bits(8'h01, 8, r);
    check("t5_miso_b0", 32'(r), 32'd0);
    spi_bits(8'h11, 8, r);
    check("t5_miso_b1", 32'(r), 32'd0);
    spi_bits(8'hFF, 8, r);
    check("t5_miso_b2", 32'(r), 32'd0);
    spi_bits(8'hFF, 8, r);
    check("t5_miso_b3", 32'(r), 32'd0);
    cs_hi();
    check("t5_store1", 32'(mem[1]), 32'h11);
    check("t5_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 6: reset in the middle of a read data word
    exp_rd.push_back(7'd1);
    cs_lo();
    spi_bits(8'h81, 8, r);
    spi_bits(8'h00, 4, r);
    check("t6_oe_before", 32'(miso_oe), 32'd1);
    f0 = ferr_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_miso", 32'(miso), 32'd0);
    check("t6_oe", 32'(miso_oe), 32'd0);
    check("t6_wr", 32'(bus.wr), 32'd0);
    check("t6_rd", 32'(bus.rd), 32'd0);
    check("t6_addr", 32'(bus.addr), 32'd0);
    check("t6_data_in", 32'(bus.data_in), 32'd0);
    check("t6_ferr", 32'(frame_err), 32'd0);
    #99;
    rst_n = 1'b1;
    spi_bits(8'h00, 4, r);
    check("t6_idle_miso", 32'(r), 32'd0);
    cs_hi();
    check("t6_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    do_read(7'd1, 8'h00);

    check("end_wr_q", 32'(exp_wr.size()), 32'd0);
    check("end_rd_q", 32'(exp_rd.size()), 32'd0);
    check("end_miso_q", 32'(exp_miso.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
